wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back sink of the MEM/WB pipeline register: the architectural GPR file plus HI/LO registers.
//  Accepts one GPR write (addr/enable/data) and one HI/LO write per cycle from the WB stage.
//  Serves two combinational GPR read ports to ID and the current HI/LO pair to EX.
//  Architectural state of the core lives only here; every retired result lands here.
// PARAMETERS
//  DATA_W    32  width of GPR, HI and LO words
//  ADDR_W    5   GPR address width
//  NUM_REGS  32  number of GPRs (2**ADDR_W); register 0 hardwired to zero
// PORTS
//  clk     in   1       core clock; all state updates on posedge
//  rst     in   1       synchronous reset, active-low (0 = reset)
//  we      in   1       GPR write enable (from wb_wreg)
//  waddr   in   ADDR_W  GPR write address (from wb_wd)
//  wdata   in   DATA_W  GPR write data (from wb_wdata)
//  whilo   in   1       HI/LO write enable (from wb_whilo)
//  hi_i    in   DATA_W  HI write data (from wb_hi)
//  lo_i    in   DATA_W  LO write data (from wb_lo)
//  re1     in   1       read port 1 enable
//  raddr1  in   ADDR_W  read port 1 address
//  rdata1  out  DATA_W  read port 1 data (combinational)
//  re2     in   1       read port 2 enable
//  raddr2  in   ADDR_W  read port 2 address
//  rdata2  out  DATA_W  read port 2 data (combinational)
//  hi_o    out  DATA_W  current HI value
//  lo_o    out  DATA_W  current LO value
// BEHAVIOUR
//  - Reset: one clock edge with rst=0 clears all GPRs, HI, LO to 0. While rst=0, rdata1/rdata2 = 0 and hi_o/lo_o = 0.
//  - GPR write: posedge with rst=1, we=1, waddr!=0 -> regs[waddr] <= wdata. Writes to addr 0 are discarded.
//  - HI/LO write: posedge with rst=1, whilo=1 -> HI <= hi_i, LO <= lo_i, both in the same cycle. Never write only one.
//  - GPR and HI/LO writes are independent; both may occur in one cycle.
//  - Read priority, per port: rst=0 -> 0; re=0 -> 0; raddr=0 -> 0; bypass hit (see CONFIGURATION) -> wdata; else regs[raddr].
//  - Read latency 0 (combinational); a write becomes visible from storage on the cycle after its edge.
//  - Both ports may read the same address; each sees an identical value.
//  - hi_o/lo_o: with HILO bypass (see CONFIGURATION) return hi_i/lo_i when whilo=1, else stored HI/LO.
//  - Reset asserted mid-stream overrides any concurrent we/whilo; the write is lost.
//  - X on waddr/wdata with we=0 must not alter state.
// CONFIGURATION
//  Macro WB_REGFILE_BYPASS_EN:
//   defined  : write-through forwarding. A read with re=1, we=1, raddr==waddr!=0 returns wdata in the same cycle,
//              and hi_o/lo_o return hi_i/lo_i when whilo=1. Removes the WB->ID hazard.
//   undefined: reads and hi_o/lo_o always return stored state. The pipeline resolves the WB->ID hazard by
//              stalling 1 cycle. No bypass muxes are synthesised.
// STRUCTURE
//  - Shared defines: RegBus, RegAddrBus, RegNum, ZeroWord, WriteEnable/Disable, ReadEnable/Disable, NOPRegAddr.
//    Add RstActiveLow to the shared defines for this block's active-low reset value.
//  - The GPR array, write logic and two read muxes live in wb_regfile itself.
//  - Sub-module hilo_reg (instantiated once): holds the HI/LO pair, handles their write, reset and optional bypass.
// TESTING
//  1. Reset: rst=0 for 1 cycle after random writes -> all 32 GPRs, HI, LO read 0; rdata=0 while rst=0.
//  2. Write/read: we=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr1=5, re1=1 -> rdata1=0xDEADBEEF.
//     re1=0 -> rdata1=0.
//  3. R0: we=1, waddr=0, wdata=0xFFFFFFFF -> raddr1=raddr2=0 read 0 on every later cycle.
//  4. Same-cycle hazard: we=1, waddr=7, wdata=0x12345678 with regs[7]=0x1, raddr2=7 ->
//     rdata2=0x12345678 if WB_REGFILE_BYPASS_EN defined, else 0x1.
//  5. HI/LO: whilo=1, hi_i=0xA, lo_i=0xB alongside we=1, waddr=3 -> next cycle hi_o=0xA, lo_o=0xB, regs[3] updated.
//     whilo=0 holds HI/LO.
//  6. Reset collision: rst=0 with we=1, waddr=9 and whilo=1 -> after the edge regs[9]=0, HI=LO=0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the write-back register file.
// Reset is active-low; RstActiveLow names that level.
package wb_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [DATA_W-1:0] reg_bus_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam logic RstActiveLow  = 1'b0;
  localparam logic WriteEnable   = 1'b1;
  localparam logic WriteDisable  = 1'b0;
  localparam logic ReadEnable    = 1'b1;
  localparam logic ReadDisable   = 1'b0;

  localparam reg_bus_t  ZeroWord   = '0;
  localparam reg_addr_t NOPRegAddr = '0;
  localparam int        RegNum     = NUM_REGS;

  // True when a GPR address is the hardwired zero register.
  function automatic logic is_zero_addr(input reg_addr_t a);
    return a == NOPRegAddr;
  endfunction

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair written together from WB.
// Optional same-cycle forwarding under WB_REGFILE_BYPASS_EN.
module hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // HI and LO always update as a pair; reset wins over a write.
  always_ff @(posedge clk) begin
    if (rst == RstActiveLow) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (whilo == WriteEnable) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  // Present stored pair, or the incoming pair when forwarding.
  always_comb begin
    hi_o = '0;
    lo_o = '0;
    if (rst == RstActiveLow) begin
      hi_o = '0;
      lo_o = '0;
`ifdef WB_REGFILE_BYPASS_EN
    end else if (whilo == WriteEnable) begin
      hi_o = hi_i;
      lo_o = lo_i;
`endif
    end else begin
      hi_o = hi_q;
      lo_o = lo_q;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Architectural GPR file plus HI/LO, fed by the WB stage.
// Define WB_REGFILE_BYPASS_EN for write-through read forwarding.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W   = wb_regfile_pkg::ADDR_W,
  parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic wr_ok;
  assign wr_ok = (we == WriteEnable) && (waddr != '0);

  // Clear every GPR on reset; otherwise commit non-zero-address writes.
  always_ff @(posedge clk) begin
    if (rst == RstActiveLow) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1: reset, disable and r0 force zero ahead of storage.
  always_comb begin
    rdata1 = '0;
    if (rst == RstActiveLow) begin
      rdata1 = '0;
    end else if (re1 == ReadDisable) begin
      rdata1 = '0;
    end else if (raddr1 == '0) begin
      rdata1 = '0;
`ifdef WB_REGFILE_BYPASS_EN
    end else if (we == WriteEnable && raddr1 == waddr) begin
      rdata1 = wdata;
`endif
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rdata2 = '0;
    if (rst == RstActiveLow) begin
      rdata2 = '0;
    end else if (re2 == ReadDisable) begin
      rdata2 = '0;
    end else if (raddr2 == '0) begin
      rdata2 = '0;
`ifdef WB_REGFILE_BYPASS_EN
    end else if (we == WriteEnable && raddr2 == waddr) begin
      rdata2 = wdata;
`endif
    end else begin
      rdata2 = regs[raddr2];
    end
  end

  hilo_reg #(
    .DATA_W(DATA_W)
  ) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .whilo(whilo),
    .hi_i (hi_i),
    .lo_i (lo_i),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
// Expectations follow WB_REGFILE_BYPASS_EN when defined.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        whilo;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .whilo (whilo),
    .hi_i  (hi_i),
    .lo_i  (lo_i),
    .re1   (re1),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .re2   (re2),
    .raddr2(raddr2),
    .rdata2(rdata2),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Storage-only expectation, replaced by wdata on a forwarding hit.
  function automatic logic [31:0] exp_rd(input vec_t v, input logic re,
                                         input logic [4:0] ra,
                                         input logic [31:0] st);
`ifdef WB_REGFILE_BYPASS_EN
    if (re && v.we && ra != 5'd0 && ra == v.waddr) return v.wdata;
`endif
    return st;
  endfunction

  function automatic logic [31:0] exp_hl(input vec_t v, input logic [31:0] in,
                                         input logic [31:0] st);
`ifdef WB_REGFILE_BYPASS_EN
    if (v.whilo) return in;
`endif
    return st;
  endfunction

  function automatic vec_t mk(
    input logic we_, input logic [4:0] wa, input logic [31:0] wd,
    input logic wh, input logic [31:0] h, input logic [31:0] l,
    input logic r1, input logic [4:0] a1,
    input logic r2, input logic [4:0] a2,
    input logic [31:0] x1, input logic [31:0] x2,
    input logic [31:0] xh, input logic [31:0] xl);
    vec_t v;
    v.we = we_; v.waddr = wa; v.wdata = wd;
    v.whilo = wh; v.hi = h; v.lo = l;
    v.re1 = r1; v.ra1 = a1; v.re2 = r2; v.ra2 = a2;
    v.e1 = x1; v.e2 = x2; v.ehi = xh; v.elo = xl;
    return v;
  endfunction

  task automatic idle();
    we = 0; waddr = 0; wdata = 0;
    whilo = 0; hi_i = 0; lo_i = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
  endtask

  initial begin
    // Stored-state expectations; exp_rd/exp_hl add forwarding.
    vt[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 0, 0,
                0, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 5,
                32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 5, 1, 5,
                0, 32'hDEADBEEF, 0, 0);
    vt[3]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0,
                0, 0, 0, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0,
                0, 0, 0, 0);
    vt[5]  = mk(1, 7, 32'h1, 0, 0, 0, 1, 7, 0, 0,
                0, 0, 0, 0);
    vt[6]  = mk(1, 7, 32'h12345678, 0, 0, 0, 1, 7, 1, 7,
                32'h1, 32'h1, 0, 0);
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 1, 7, 1, 0,
                32'h12345678, 0, 0, 0);
    vt[8]  = mk(1, 3, 32'hCAFE0003, 1, 32'hA, 32'hB, 1, 3, 0, 0,
                0, 0, 0, 0);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0,
                32'hCAFE0003, 0, 32'hA, 32'hB);
    vt[10] = mk(0, 0, 0, 0, 32'h5, 32'h6, 0, 0, 1, 5,
                0, 32'hDEADBEEF, 32'hA, 32'hB);
    vt[11] = mk(0, 0, 0, 1, 32'h11, 32'h22, 1, 0, 0, 0,
                0, 0, 32'hA, 32'hB);
    vt[12] = mk(1, 31, 32'h80000001, 0, 0, 0, 1, 0, 1, 3,
                0, 32'hCAFE0003, 32'h11, 32'h22);
    vt[13] = mk(0, 0, 0, 0, 0, 0, 1, 31, 1, 31,
                32'h80000001, 32'h80000001, 32'h11, 32'h22);
    vt[14] = mk(0, 5'bx, 32'hx, 0, 0, 0, 1, 7, 1, 31,
                32'h12345678, 32'h80000001, 32'h11, 32'h22);
    vt[15] = mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 0,
                32'hDEADBEEF, 0, 32'h11, 32'h22);

    idle();
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;

    // Fill every GPR and HI/LO with non-zero data.
    for (int i = 1; i < 32; i++) begin
      we = 1; waddr = 5'(i); wdata = $urandom | 32'h1;
      @(negedge clk);
    end
    we = 0; whilo = 1;
    hi_i = $urandom | 32'h1; lo_i = $urandom | 32'h1;
    @(negedge clk);
    whilo = 0; re1 = 1; raddr1 = 9;
    #2 chk("pre_reset_r9_nonzero", 32'(rdata1 != 0), 32'd1);

    // Reset colliding with GPR and HI/LO writes.
    @(negedge clk);
    rst = 0;
    we = 1; waddr = 9; wdata = 32'h99999999;
    whilo = 1; hi_i = 32'h77; lo_i = 32'h88;
    re1 = 1; raddr1 = 9; re2 = 1; raddr2 = 4;
    #2;
    chk("rst_rdata1", rdata1, 0);
    chk("rst_rdata2", rdata2, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    @(negedge clk);
    rst = 1;
    idle();
    for (int i = 0; i < 32; i++) begin
      re1 = 1; raddr1 = 5'(i);
      re2 = 1; raddr2 = 5'(31 - i);
      #1;
      chk($sformatf("clr_p1_r%0d", i), rdata1, 0);
      chk($sformatf("clr_p2_r%0d", 31 - i), rdata2, 0);
    end
    chk("clr_hi", hi_o, 0);
    chk("clr_lo", lo_o, 0);

    // Table: drive on negedge, check before the posedge commits.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      we = vt[k].we; waddr = vt[k].waddr; wdata = vt[k].wdata;
      whilo = vt[k].whilo; hi_i = vt[k].hi; lo_i = vt[k].lo;
      re1 = vt[k].re1; raddr1 = vt[k].ra1;
      re2 = vt[k].re2; raddr2 = vt[k].ra2;
      #2;
      chk($sformatf("v%0d_rdata1", k), rdata1,
          exp_rd(vt[k], vt[k].re1, vt[k].ra1, vt[k].e1));
      chk($sformatf("v%0d_rdata2", k), rdata2,
          exp_rd(vt[k], vt[k].re2, vt[k].ra2, vt[k].e2));
      chk($sformatf("v%0d_hi", k), hi_o,
          exp_hl(vt[k], vt[k].hi, vt[k].ehi));
      chk($sformatf("v%0d_lo", k), lo_o,
          exp_hl(vt[k], vt[k].lo, vt[k].elo));
    end

    // Second mid-stream reset after state is populated.
    @(negedge clk);
    idle();
    rst = 0; we = 1; waddr = 7; wdata = 32'h55;
    whilo = 1; hi_i = 32'h66; lo_i = 32'h67;
    @(negedge clk);
    rst = 1; idle();
    re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 31;
    #2;
    chk("rst2_r7", rdata1, 0);
    chk("rst2_r31", rdata2, 0);
    chk("rst2_hi", hi_o, 0);
    chk("rst2_lo", lo_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
